// File: rtl/i2c_bus_framer.sv
// rtl/i2c_bus_framer.sv - I2C bus condition detector and byte framer (sync, glitch filter, FSM)
module i2c_bus_framer #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3,
    parameter int CNT_W       = 8
) (
    input  logic             system_clock,
    input  logic             reset,
    input  logic             scl_in,
    input  logic             sda_in,
    output logic             start_det,
    output logic             rstart_det,
    output logic             stop_det,
    output logic             bus_busy,
    output logic             byte_valid,
    output logic [7:0]       byte_data,
    output logic             byte_ack,
    output logic             byte_is_addr,
    output logic             rw_bit,
    output logic [CNT_W-1:0] byte_cnt,
    output logic             frame_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ACK   = 2'd2
    } state_t;

    localparam logic [3:0]       FILT_LAST = 4'(FILTER_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_s, sda_s;
    logic [3:0]             scl_fcnt, sda_fcnt;
    logic                   scl_f, sda_f, scl_f_d, sda_f_d;
    logic                   scl_rise, scl_fall, sda_rise, sda_fall;
    logic                   start_cond, stop_cond;

    state_t           state, state_nxt;
    logic [3:0]       bit_cnt, bit_cnt_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic             addr_pend, addr_pend_nxt;
    logic             start_nxt, rstart_nxt, stop_nxt, valid_nxt, err_nxt;
    logic             busy_nxt, ack_nxt, is_addr_nxt, rw_nxt;
    logic [7:0]       data_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
        end
    end

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    // A line flips only after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
            scl_fcnt <= '0;
            sda_fcnt <= '0;
            scl_f_d  <= 1'b1;
            sda_f_d  <= 1'b1;
        end else begin
            scl_f_d <= scl_f;
            sda_f_d <= sda_f;
            if (scl_s != scl_f) begin
                if (scl_fcnt == FILT_LAST) begin
                    scl_f    <= scl_s;
                    scl_fcnt <= '0;
                end else begin
                    scl_fcnt <= scl_fcnt + 4'd1;
                end
            end else begin
                scl_fcnt <= '0;
            end
            if (sda_s != sda_f) begin
                if (sda_fcnt == FILT_LAST) begin
                    sda_f    <= sda_s;
                    sda_fcnt <= '0;
                end else begin
                    sda_fcnt <= sda_fcnt + 4'd1;
                end
            end else begin
                sda_fcnt <= '0;
            end
        end
    end

    assign scl_rise = scl_f & ~scl_f_d;
    assign scl_fall = ~scl_f & scl_f_d;
    assign sda_rise = sda_f & ~sda_f_d;
    assign sda_fall = ~sda_f & sda_f_d;

    // An SDA edge coinciding with SCL falling is data movement, not a condition.
    assign start_cond = sda_fall & scl_f & ~scl_fall;
    assign stop_cond  = sda_rise & scl_f & ~scl_fall;

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        shreg_nxt     = shreg;
        addr_pend_nxt = addr_pend;
        busy_nxt      = bus_busy;
        data_nxt      = byte_data;
        ack_nxt       = byte_ack;
        is_addr_nxt   = byte_is_addr;
        rw_nxt        = rw_bit;
        cnt_nxt       = byte_cnt;
        start_nxt     = 1'b0;
        rstart_nxt    = 1'b0;
        stop_nxt      = 1'b0;
        valid_nxt     = 1'b0;
        err_nxt       = 1'b0;

        if (stop_cond) begin
            stop_nxt      = 1'b1;
            err_nxt       = (bit_cnt != 4'd0);
            busy_nxt      = 1'b0;
            bit_cnt_nxt   = 4'd0;
            addr_pend_nxt = 1'b0;
            state_nxt     = IDLE;
        end else if (start_cond) begin
            if (state == IDLE) begin
                start_nxt = 1'b1;
            end else begin
                rstart_nxt = 1'b1;
                err_nxt    = (bit_cnt != 4'd0);
            end
            busy_nxt      = 1'b1;
            cnt_nxt       = '0;
            bit_cnt_nxt   = 4'd0;
            addr_pend_nxt = 1'b1;
            state_nxt     = SHIFT;
        end else if (scl_rise) begin
            case (state)
                SHIFT: begin
                    shreg_nxt   = {shreg[6:0], sda_f};
                    bit_cnt_nxt = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        state_nxt = ACK;
                    end
                end
                ACK: begin
                    ack_nxt     = sda_f;
                    data_nxt    = shreg;
                    valid_nxt   = 1'b1;
                    is_addr_nxt = addr_pend;
                    if (addr_pend) begin
                        rw_nxt        = shreg[0];
                        addr_pend_nxt = 1'b0;
                    end
                    if (byte_cnt != CNT_MAX) begin
                        cnt_nxt = byte_cnt + 1'b1;
                    end
                    bit_cnt_nxt = 4'd0;
                    state_nxt   = SHIFT;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            bit_cnt      <= 4'd0;
            shreg        <= 8'h00;
            addr_pend    <= 1'b0;
            bus_busy     <= 1'b0;
            byte_data    <= 8'h00;
            byte_ack     <= 1'b1;
            byte_is_addr <= 1'b0;
            rw_bit       <= 1'b0;
            byte_cnt     <= '0;
            start_det    <= 1'b0;
            rstart_det   <= 1'b0;
            stop_det     <= 1'b0;
            byte_valid   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state        <= state_nxt;
            bit_cnt      <= bit_cnt_nxt;
            shreg        <= shreg_nxt;
            addr_pend    <= addr_pend_nxt;
            bus_busy     <= busy_nxt;
            byte_data    <= data_nxt;
            byte_ack     <= ack_nxt;
            byte_is_addr <= is_addr_nxt;
            rw_bit       <= rw_nxt;
            byte_cnt     <= cnt_nxt;
            start_det    <= start_nxt;
            rstart_det   <= rstart_nxt;
            stop_det     <= stop_nxt;
            byte_valid   <= valid_nxt;
            frame_err    <= err_nxt;
        end
    end

endmodule

// File: tb/tb_i2c_bus_framer.sv
// tb/tb_i2c_bus_framer.sv - directed table-driven bench for i2c_bus_framer
module tb_i2c_bus_framer;

    localparam int PH = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl, sda;

    logic       start_det, rstart_det, stop_det, bus_busy, byte_valid;
    logic [7:0] byte_data;
    logic       byte_ack, byte_is_addr, rw_bit, frame_err;
    logic [7:0] byte_cnt;

    logic       d2_start, d2_rstart, d2_stop, d2_busy, d2_valid;
    logic [7:0] d2_data;
    logic       d2_ack, d2_is_addr, d2_rw, d2_err;
    logic [1:0] d2_cnt;

    i2c_bus_framer dut (
        .system_clock(clk), .reset(reset), .scl_in(scl), .sda_in(sda),
        .start_det(start_det), .rstart_det(rstart_det), .stop_det(stop_det),
        .bus_busy(bus_busy), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ack(byte_ack), .byte_is_addr(byte_is_addr), .rw_bit(rw_bit),
        .byte_cnt(byte_cnt), .frame_err(frame_err)
    );

    i2c_bus_framer #(.CNT_W(2)) dut2 (
        .system_clock(clk), .reset(reset), .scl_in(scl), .sda_in(sda),
        .start_det(d2_start), .rstart_det(d2_rstart), .stop_det(d2_stop),
        .bus_busy(d2_busy), .byte_valid(d2_valid), .byte_data(d2_data),
        .byte_ack(d2_ack), .byte_is_addr(d2_is_addr), .rw_bit(d2_rw),
        .byte_cnt(d2_cnt), .frame_err(d2_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_start = 0, n_rstart = 0, n_stop = 0, n_valid = 0, n_err = 0, n_err_stop = 0;
    logic [7:0] last_data;
    logic       last_ack, last_addr, last_rw;
    logic [7:0] last_cnt;
    int         q2[$];

    always @(negedge clk) begin
        if (!reset) begin
            if (start_det)  n_start++;
            if (rstart_det) n_rstart++;
            if (stop_det)   n_stop++;
            if (frame_err)  n_err++;
            if (frame_err && stop_det) n_err_stop++;
            if (byte_valid) begin
                n_valid++;
                last_data = byte_data;
                last_ack  = byte_ack;
                last_addr = byte_is_addr;
                last_rw   = rw_bit;
                last_cnt  = byte_cnt;
            end
            if (d2_valid) q2.push_back(int'(d2_cnt));
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda = 1'b1; wait_clks(PH);
        scl = 1'b1; wait_clks(PH);
        sda = 1'b0; wait_clks(PH);
        scl = 1'b0; wait_clks(PH);
    endtask

    task automatic bus_stop();
        sda = 1'b0; wait_clks(PH);
        scl = 1'b1; wait_clks(PH);
        sda = 1'b1; wait_clks(PH);
    endtask

    task automatic bus_bit(input logic b);
        sda = b;    wait_clks(PH);
        scl = 1'b1; wait_clks(PH);
        scl = 1'b0; wait_clks(PH);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic ack);
        for (int i = 7; i >= 0; i--) bus_bit(d[i]);
        bus_bit(ack);
    endtask

    typedef struct {
        bit         start_before;
        bit         exp_rstart;
        logic [7:0] data;
        bit         ack;
        bit         stop_after;
        bit         exp_addr;
        bit         exp_rw;
        int         exp_cnt;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int v0, s0, r0, p0, e0, es0;

        vecs[0] = '{1'b1, 1'b0, 8'hA0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vecs[1] = '{1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 2};
        vecs[2] = '{1'b1, 1'b0, 8'hA0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vecs[3] = '{1'b0, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        vecs[4] = '{1'b1, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b1, 1};
        vecs[5] = '{1'b0, 1'b0, 8'h7E, 1'b1, 1'b1, 1'b0, 1'b1, 2};

        scl = 1'b1; sda = 1'b1; reset = 1'b1;
        wait_clks(4);
        check("reset_busy",     bus_busy,     0);
        check("reset_data",     byte_data,    8'h00);
        check("reset_ack",      byte_ack,     1);
        check("reset_is_addr",  byte_is_addr, 0);
        check("reset_rw",       rw_bit,       0);
        check("reset_cnt",      byte_cnt,     0);
        check("reset_pulses",   {start_det, rstart_det, stop_det, byte_valid, frame_err}, 0);
        reset = 1'b0;
        wait_clks(PH);

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].start_before) begin
                s0 = n_start; r0 = n_rstart;
                bus_start();
                check($sformatf("v%0d_start_det", i),  n_start - s0,  vecs[i].exp_rstart ? 0 : 1);
                check($sformatf("v%0d_rstart_det", i), n_rstart - r0, vecs[i].exp_rstart ? 1 : 0);
                check($sformatf("v%0d_busy", i),       bus_busy,      1);
            end
            v0 = n_valid;
            send_byte(vecs[i].data, vecs[i].ack);
            check($sformatf("v%0d_valid_cnt", i), n_valid - v0, 1);
            check($sformatf("v%0d_data", i),      last_data,    vecs[i].data);
            check($sformatf("v%0d_ack", i),       last_ack,     vecs[i].ack);
            check($sformatf("v%0d_is_addr", i),   last_addr,    vecs[i].exp_addr);
            check($sformatf("v%0d_rw", i),        last_rw,      vecs[i].exp_rw);
            check($sformatf("v%0d_cnt", i),       last_cnt,     vecs[i].exp_cnt);
            if (vecs[i].stop_after) begin
                p0 = n_stop;
                bus_stop();
                wait_clks(PH);
                check($sformatf("v%0d_stop_det", i), n_stop - p0, 1);
                check($sformatf("v%0d_idle", i),     bus_busy,    0);
            end
        end

        // Partial byte then STOP.
        v0 = n_valid; es0 = n_err_stop;
        bus_start();
        bus_bit(1'b1); bus_bit(1'b0); bus_bit(1'b1); bus_bit(1'b0);
        bus_stop();
        wait_clks(PH);
        check("partial_err_with_stop", n_err_stop - es0, 1);
        check("partial_no_valid",      n_valid - v0,     0);
        check("partial_idle",          bus_busy,         0);

        // One-cycle SDA glitch with SCL high.
        s0 = n_start;
        sda = 1'b0; wait_clks(1);
        sda = 1'b1; wait_clks(3 * PH);
        check("glitch_no_start", n_start - s0, 0);
        check("glitch_not_busy", bus_busy,     0);

        // STOP while idle: pulsed, no error.
        p0 = n_stop; e0 = n_err;
        scl = 1'b0; wait_clks(PH);
        sda = 1'b0; wait_clks(PH);
        scl = 1'b1; wait_clks(PH);
        sda = 1'b1; wait_clks(PH);
        check("idle_stop_det", n_stop - p0, 1);
        check("idle_stop_err", n_err - e0,  0);
        check("idle_stop_busy", bus_busy,   0);

        // Reset after 5 bits, then a clean frame.
        bus_start();
        for (int i = 0; i < 5; i++) bus_bit(1'b1);
        reset = 1'b1;
        wait_clks(3);
        scl = 1'b1; sda = 1'b1;
        wait_clks(2);
        check("midreset_busy", bus_busy, 0);
        check("midreset_cnt",  byte_cnt, 0);
        reset = 1'b0;
        wait_clks(PH);
        v0 = n_valid;
        bus_start();
        send_byte(8'hA0, 1'b0);
        check("after_reset_valid",   n_valid - v0, 1);
        check("after_reset_data",    last_data,    8'hA0);
        check("after_reset_is_addr", last_addr,    1);
        check("after_reset_cnt",     last_cnt,     1);
        bus_stop();
        wait_clks(PH);

        // Saturating counter on the 2-bit instance.
        q2.delete();
        bus_start();
        send_byte(8'hA0, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        bus_stop();
        wait_clks(PH);
        check("sat_count_len", q2.size(), 5);
        if (q2.size() == 5) begin
            check("sat_cnt0", q2[0], 1);
            check("sat_cnt1", q2[1], 2);
            check("sat_cnt2", q2[2], 3);
            check("sat_cnt3", q2[3], 3);
            check("sat_cnt4", q2[4], 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
